// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard detection for a 5-stage in-order pipeline: a small destination
// scoreboard mirroring EX/MEM/WB drives stall/flush controls and perf counters.
module pipeline_hazard_ctrl #(
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_RegWrite,
    input  logic             mem_redirect,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sb_entry_t        sb_ex_q, sb_ex_d;
    sb_entry_t        sb_mem_q, sb_mem_d;
    sb_entry_t        sb_wb_q, sb_wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    sb_entry_t id_entry;
    logic      match_rs1;
    logic      match_rs2;
    logic      hz;
    logic      stall;

    function automatic logic src_match(
        input logic       use_s,
        input logic [4:0] addr,
        input sb_entry_t  ex_e,
        input sb_entry_t  mem_e,
        input sb_entry_t  wb_e
    );
        logic hit;
        hit = (ex_e.v  && (ex_e.rd  == addr)) ||
              (mem_e.v && (mem_e.rd == addr)) ||
              ((WB_BYPASS == 0) && wb_e.v && (wb_e.rd == addr));
        return use_s && (addr != 5'd0) && hit;
    endfunction

    always_comb begin
        id_entry.v  = id_valid && id_RegWrite && (id_rd_addr != 5'd0);
        id_entry.rd = id_rd_addr;

        match_rs1 = src_match(id_use_rs1, id_rs1_addr, sb_ex_q, sb_mem_q, sb_wb_q);
        match_rs2 = src_match(id_use_rs2, id_rs2_addr, sb_ex_q, sb_mem_q, sb_wb_q);
        hz        = id_valid && (match_rs1 || match_rs2);
        stall     = hz && !mem_redirect;

        PC_EN       = !stall;
        IFID_EN     = !stall;
        IDEX_flush  = stall || mem_redirect;
        IFID_flush  = mem_redirect;
        EXMEM_flush = mem_redirect;
    end

    // The redirecting instruction sits in MEM and still retires, so it moves
    // to WB while everything younger is squashed.
    always_comb begin
        sb_wb_d     = sb_mem_q;
        sb_mem_d    = sb_ex_q;
        sb_ex_d     = id_entry;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (mem_redirect) begin
            sb_mem_d = '0;
            sb_ex_d  = '0;
        end else if (stall) begin
            sb_ex_d = '0;
        end

        if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (mem_redirect) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end

        if (rst) begin
            sb_wb_d     = '0;
            sb_mem_d    = '0;
            sb_ex_d     = '0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        sb_ex_q     <= sb_ex_d;
        sb_mem_q    <= sb_mem_d;
        sb_wb_q     <= sb_wb_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded random + directed bench for pipeline_hazard_ctrl, driving a
// no-bypass and a bypass instance in parallel against an issue-history model.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        bit          pc_en;
        bit          ifid_en;
        bit          ifid_fl;
        bit          idex_fl;
        bit          exmem_fl;
        bit [CW-1:0] scnt;
        bit [CW-1:0] fcnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs1_addr;
    logic [4:0]    id_rs2_addr;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [4:0]    id_rd_addr;
    logic          id_RegWrite;
    logic          mem_redirect;

    logic          pc_en0, ifid_en0, ifid_fl0, idex_fl0, exmem_fl0;
    logic          pc_en1, ifid_en1, ifid_fl1, idex_fl1, exmem_fl1;
    logic [CW-1:0] scnt0, fcnt0, scnt1, fcnt1;

    pipeline_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(CW)) u_nobyp (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd_addr(id_rd_addr), .id_RegWrite(id_RegWrite),
        .mem_redirect(mem_redirect),
        .PC_EN(pc_en0), .IFID_EN(ifid_en0), .IFID_flush(ifid_fl0),
        .IDEX_flush(idex_fl0), .EXMEM_flush(exmem_fl0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    pipeline_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(CW)) u_byp (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd_addr(id_rd_addr), .id_RegWrite(id_RegWrite),
        .mem_redirect(mem_redirect),
        .PC_EN(pc_en1), .IFID_EN(ifid_en1), .IFID_flush(ifid_fl1),
        .IDEX_flush(idex_fl1), .EXMEM_flush(exmem_fl1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Model: per instance, the destinations issued into EX in cycle order
    // (0 = nothing tracked). The newest entry is in EX, then MEM, then WB.
    int   hist [2][$];
    int   m_scnt [2];
    int   m_fcnt [2];
    bit   last_stall [2];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int b, input logic [4:0] a, input logic u);
        int depth = (b == 1) ? 2 : 3;
        int n = hist[b].size();
        if (!u || a == 5'd0) return 0;
        for (int i = 0; i < depth; i++) begin
            if (n - 1 - i >= 0 && hist[b][n - 1 - i] == int'(a)) return 1;
        end
        return 0;
    endfunction

    task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic redir, input logic r);
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_use_rs1   = u1;
        id_rs2_addr  = rs2;
        id_use_rs2   = u2;
        id_rd_addr   = rd;
        id_RegWrite  = rw;
        mem_redirect = redir;
        rst          = r;
        for (int b = 0; b < 2; b++) begin
            bit   st;
            exp_t e;
            int   ent;
            st = v && (m_hit(b, rs1, u1) || m_hit(b, rs2, u2)) && !redir;
            last_stall[b] = st;
            e.pc_en    = !st;
            e.ifid_en  = !st;
            e.ifid_fl  = redir;
            e.idex_fl  = st || redir;
            e.exmem_fl = redir;
            e.scnt     = CW'(m_scnt[b]);
            e.fcnt     = CW'(m_fcnt[b]);
            if (b == 0) q0.push_back(e); else q1.push_back(e);
            if (r) begin
                hist[b].delete();
                m_scnt[b] = 0;
                m_fcnt[b] = 0;
            end else begin
                ent = (v && rw && rd != 5'd0) ? int'(rd) : 0;
                if (redir) begin
                    if (hist[b].size() > 0) hist[b][hist[b].size() - 1] = 0;
                    hist[b].push_back(0);
                end else if (st) begin
                    hist[b].push_back(0);
                end else begin
                    hist[b].push_back(ent);
                end
                if (hist[b].size() > 8) void'(hist[b].pop_front());
                m_scnt[b] = (m_scnt[b] + int'(st)) % (1 << CW);
                m_fcnt[b] = (m_fcnt[b] + int'(redir)) % (1 << CW);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Issue one instruction, holding it in ID while the no-bypass model stalls.
    task automatic issue(input logic [4:0] rd, input logic rw, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2, input logic u2);
        int n = 0;
        do begin
            cyc(1, rs1, u1, rs2, u2, rd, rw, 0, 0);
            n++;
        end while (last_stall[0] && n < 8);
    endtask

    task automatic cmp_inst(input string tag, input exp_t e, input exp_t a);
        chk({tag, ".PC_EN"},       int'(a.pc_en),    int'(e.pc_en));
        chk({tag, ".IFID_EN"},     int'(a.ifid_en),  int'(e.ifid_en));
        chk({tag, ".IFID_flush"},  int'(a.ifid_fl),  int'(e.ifid_fl));
        chk({tag, ".IDEX_flush"},  int'(a.idex_fl),  int'(e.idex_fl));
        chk({tag, ".EXMEM_flush"}, int'(a.exmem_fl), int'(e.exmem_fl));
        chk({tag, ".stall_cnt"},   int'(a.scnt),     int'(e.scnt));
        chk({tag, ".flush_cnt"},   int'(a.fcnt),     int'(e.fcnt));
    endtask

    // Monitor: the controls are live every cycle, so each negedge consumes one entry.
    initial begin
        exp_t a;
        while (!done) begin
            @(negedge clk);
            if (q0.size() > 0) begin
                a = '{pc_en0, ifid_en0, ifid_fl0, idex_fl0, exmem_fl0, scnt0, fcnt0};
                cmp_inst("nobyp", q0.pop_front(), a);
            end
            if (q1.size() > 0) begin
                a = '{pc_en1, ifid_en1, ifid_fl1, idex_fl1, exmem_fl1, scnt1, fcnt1};
                cmp_inst("byp", q1.pop_front(), a);
            end
        end
    end

    initial begin
        int n;
        rst = 1; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_use_rs1 = 0;
        id_use_rs2 = 0; id_rd_addr = 0; id_RegWrite = 0; mem_redirect = 0;
        for (int b = 0; b < 2; b++) begin
            m_scnt[b] = 0; m_fcnt[b] = 0; last_stall[b] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        nop();

        // Back-to-back RAW: addi x5; add x6,x5,x1
        issue(5, 1, 0, 1, 0, 0);
        issue(6, 1, 5, 1, 1, 1);
        repeat (3) nop();
        chk("b2b_stall_nobyp", int'(scnt0), 3);
        chk("b2b_stall_byp",   int'(scnt1), 2);

        // Distance-2 dependency
        do_reset();
        issue(5, 1, 0, 1, 0, 0);
        issue(7, 1, 2, 1, 3, 1);
        issue(6, 1, 5, 1, 0, 0);
        repeat (3) nop();
        chk("dist2_stall_nobyp", int'(scnt0), 2);
        chk("dist2_stall_byp",   int'(scnt1), 1);

        // Distance-4 dependency
        do_reset();
        issue(5, 1, 0, 1, 0, 0);
        issue(7, 1, 2, 1, 0, 0);
        issue(8, 1, 2, 1, 0, 0);
        issue(9, 1, 2, 1, 0, 0);
        issue(6, 1, 5, 1, 5, 1);
        chk("dist4_stall_nobyp", int'(scnt0), 0);

        // x0 as producer and source
        do_reset();
        issue(0, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 6, 1, 0, 0);
        chk("x0_pc_en", int'(pc_en0), 1);
        chk("x0_stall_cnt", int'(scnt0), 0);

        // Redirect while a stall on EX is pending
        do_reset();
        issue(5, 1, 0, 1, 0, 0);
        cyc(1, 5, 1, 0, 0, 6, 1, 0, 0);
        cyc(1, 5, 1, 0, 0, 6, 1, 1, 0);
        chk("redir_flush_cnt", int'(fcnt0), 1);
        chk("redir_stall_cnt", int'(scnt0), 1);
        nop();

        // JAL x1 redirects from MEM; the target reads x1
        do_reset();
        issue(1, 1, 0, 0, 0, 0);
        nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        issue(6, 1, 1, 1, 0, 0);
        chk("jal_stall_nobyp", int'(scnt0), 1);
        chk("jal_stall_byp",   int'(scnt1), 0);

        // Reset in the second stall cycle
        do_reset();
        issue(5, 1, 0, 1, 0, 0);
        cyc(1, 5, 1, 0, 0, 6, 1, 0, 0);
        cyc(1, 5, 1, 0, 0, 6, 1, 0, 1);
        chk("rst_mid_pc_en", int'(pc_en0), 1);
        chk("rst_mid_stall_cnt", int'(scnt0), 0);
        nop();

        // Counter wrap: drive stall_cnt to all-ones, then one more stall
        do_reset();
        n = 0;
        while (m_scnt[0] != (1 << CW) - 1 && n < 200) begin
            cyc(1, 5, 1, 0, 0, 5, 1, 0, 0);
            n++;
        end
        chk("wrap_reach_max", int'(scnt0), (1 << CW) - 1);
        n = 0;
        do begin
            cyc(1, 5, 1, 0, 0, 5, 1, 0, 0);
            n++;
        end while (!last_stall[0] && n < 8);
        chk("wrap_to_zero", int'(scnt0), 0);

        // Random traffic over a narrow register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom),
                1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 99) == 0));
        end
        nop();

        done = 1;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q0.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
